// File: rtl/key_pkg.sv
// Shared types and constants for the key conditioning front end.
// Debouncer state encoding plus the sim/hardware debounce lengths.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

  localparam int DEBOUNCE_SIM = 4;
  localparam int DEBOUNCE_HW  = 500000;

endpackage

// File: rtl/key_conditioner_if.sv
// Key/pulse bundle between the pushbuttons and the light FSMs.
// master: drives raw keys, reads pulses/levels; slave: the conditioner.
interface key_conditioner_if;

  logic key_l_n;
  logic key_r_n;
  logic L;
  logic R;
  logic l_held;
  logic r_held;

  modport master (
    output key_l_n,
    output key_r_n,
    input  L,
    input  R,
    input  l_held,
    input  r_held
  );

  modport slave (
    input  key_l_n,
    input  key_r_n,
    output L,
    output R,
    output l_held,
    output r_held
  );

endinterface

// File: rtl/key_conditioner_debounce.sv
// One key: 2-flop synchronizer, debounce FSM and press pulse register.
// Ports: clk, reset (sync, high), key_n (raw, low=pressed) -> pulse, held.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pulse,
  output logic held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             s;

  assign s = sync2_q;

  always_comb begin
    sync1_d = ~key_n;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // bounce back to HELD never re-arms the pulse
        if (s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign held  = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/key_conditioner.sv
// Left/right key front end: two debouncers plus a same-cycle conflict filter.
// Ports: clk, reset (sync, high), kif.slave (raw keys in, L/R pulses and held levels out).
module key_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic reset,
  key_conditioner_if.slave kif
);

  logic p_l;
  logic p_r;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_l (
    .clk   (clk),
    .reset (reset),
    .key_n (kif.key_l_n),
    .pulse (p_l),
    .held  (kif.l_held)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_r (
    .clk   (clk),
    .reset (reset),
    .key_n (kif.key_r_n),
    .pulse (p_r),
    .held  (kif.r_held)
  );

  // simultaneous presses cancel so neither side gains a step
  assign kif.L = p_l & ~p_r;
  assign kif.R = p_r & ~p_l;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4.
// Edge e below is the e-th posedge after stimulus starts; checks run #1 after it.
module tb_key_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  key_conditioner_if kif();

  key_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    kif.key_l_n = 1'b1;
    kif.key_r_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_L", kif.L, 1'b0);
      chk("idle_R", kif.R, 1'b0);
    end
  endtask

  initial begin
    logic [5:0] bounce;
    reset = 1'b1;
    kif.key_l_n = 1'b1;
    kif.key_r_n = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_L", kif.L, 1'b0);
    chk("rst_R", kif.R, 1'b0);
    chk("rst_lh", kif.l_held, 1'b0);
    chk("rst_rh", kif.r_held, 1'b0);
    reset = 1'b0;
    idle(3);

    // T1: clean left press, release before edge 20
    for (int e = 0; e < 30; e++) begin
      kif.key_l_n = (e < 20) ? 1'b0 : 1'b1;
      tick();
      chk("t1_L", kif.L, 1'(e == 6));
      chk("t1_R", kif.R, 1'b0);
      chk("t1_lh", kif.l_held, 1'(e >= 6 && e < 26));
    end
    idle(3);

    // T2: right bounce 0,0,1,0,0,1 then steady low from edge 6
    bounce = 6'b100100;
    for (int e = 0; e < 20; e++) begin
      kif.key_r_n = (e < 6) ? bounce[e] : 1'b0;
      tick();
      chk("t2_R", kif.R, 1'(e == 12));
      chk("t2_L", kif.L, 1'b0);
    end
    idle(10);

    // T3: left held, then release bounce high,high,low,high...
    for (int e = 0; e < 25; e++) begin
      kif.key_l_n = (e < 10 || e == 12) ? 1'b0 : 1'b1;
      tick();
      chk("t3_L", kif.L, 1'(e == 6));
      chk("t3_lh", kif.l_held, 1'(e >= 6 && e < 19));
    end
    idle(3);

    // T4: both keys at the same edge
    for (int e = 0; e < 20; e++) begin
      kif.key_l_n = (e < 12) ? 1'b0 : 1'b1;
      kif.key_r_n = (e < 12) ? 1'b0 : 1'b1;
      tick();
      chk("t4_L", kif.L, 1'b0);
      chk("t4_R", kif.R, 1'b0);
      chk("t4_lh", kif.l_held, 1'(e >= 6 && e < 18));
      chk("t4_rh", kif.r_held, 1'(e >= 6 && e < 18));
    end
    idle(3);

    // T5: right one cycle after left
    for (int e = 0; e < 12; e++) begin
      kif.key_l_n = 1'b0;
      kif.key_r_n = (e >= 1) ? 1'b0 : 1'b1;
      tick();
      chk("t5_L", kif.L, 1'(e == 6));
      chk("t5_R", kif.R, 1'(e == 7));
    end
    idle(10);

    // T6: reset sampled at edge 4 with left still held
    for (int e = 0; e < 16; e++) begin
      kif.key_l_n = 1'b0;
      reset = (e == 4);
      tick();
      chk("t6_L", kif.L, 1'(e == 11));
      chk("t6_lh", kif.l_held, 1'(e >= 11));
    end
    reset = 1'b0;
    idle(10);
    chk("end_lh", kif.l_held, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
